// File: rtl/branch_resolve_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl_pkg
// Purpose : shared definitions for ID-stage branch resolution: branch type
//           codes, comparator operand forward-select codes, FSM state codes
//           and a helper telling which branch types read rt.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package branch_resolve_ctrl_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BGEZ = 3'd3,
    BR_BGTZ = 3'd4
  } br_type_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,  // register file value
    FWD_EXMEM = 2'd1,  // EX/MEM result (producer now in MEM, not a load)
    FWD_MEMWB = 2'd2   // MEM/WB result (producer now in WB)
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_e;

  // BEQ/BNE compare rs against rt; BGEZ/BGTZ look at rs only.
  function automatic logic br_uses_rt(input logic [2:0] br_type);
    return (br_type == BR_BEQ) || (br_type == BR_BNE);
  endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// -----------------------------------------------------------------------------
// branch_hazard_detect
// Purpose : combinational hazard check for a branch resolved in ID. Works out
//           how many stall cycles are needed before rs/rt can be forwarded to
//           the comparator, and which forwarding path feeds each operand.
// Ports   :
//   i_br_type            branch type (BR_* code)
//   i_rs, i_rt           ID source registers
//   i_ex_regwrite/memread/rd    EX producer
//   i_mem_regwrite/memread/rd   MEM producer
//   i_wb_regwrite/rd            WB producer
//   o_need               stall cycles required (0..2)
//   o_fwd_a_sel          comparator operand 0 source (FWD_* code)
//   o_fwd_b_sel          comparator operand 1 source (FWD_* code)
// -----------------------------------------------------------------------------
module branch_hazard_detect
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [2:0]      i_br_type,
  input  logic [RA_W-1:0] i_rs,
  input  logic [RA_W-1:0] i_rt,
  input  logic            i_ex_regwrite,
  input  logic            i_ex_memread,
  input  logic [RA_W-1:0] i_ex_rd,
  input  logic            i_mem_regwrite,
  input  logic            i_mem_memread,
  input  logic [RA_W-1:0] i_mem_rd,
  input  logic            i_wb_regwrite,
  input  logic [RA_W-1:0] i_wb_rd,
  output logic [1:0]      o_need,
  output logic [1:0]      o_fwd_a_sel,
  output logic [1:0]      o_fwd_b_sel
);

  logic [RA_W-1:0] w_src      [2];
  logic [1:0]      w_need_src [2];
  logic [1:0]      w_fwd_src  [2];
  logic [1:0]      w_need_b;

  assign w_src[0] = i_rs;
  assign w_src[1] = i_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic w_nz;
      logic w_ex_hit;
      logic w_mem_hit;
      logic w_wb_hit;

      // r0 is hardwired zero, so a write to it is never a real dependency.
      assign w_nz      = |w_src[gi];
      assign w_ex_hit  = w_nz & i_ex_regwrite  & (i_ex_rd  == w_src[gi]);
      assign w_mem_hit = w_nz & i_mem_regwrite & (i_mem_rd == w_src[gi]);
      assign w_wb_hit  = w_nz & i_wb_regwrite  & (i_wb_rd  == w_src[gi]);

      // The youngest producer decides: a load in EX needs two cycles to reach
      // WB, an ALU op in EX or a load in MEM needs one.
      assign w_need_src[gi] = w_ex_hit ? (i_ex_memread ? 2'd2 : 2'd1)
                            : ((w_mem_hit & i_mem_memread) ? 2'd1 : 2'd0);

      // A load in MEM has no data yet, so fall through to an older WB copy.
      assign w_fwd_src[gi] = (w_mem_hit & ~i_mem_memread) ? FWD_EXMEM
                           : w_wb_hit                     ? FWD_MEMWB
                           :                                FWD_RF;
    end
  endgenerate

  assign w_need_b    = br_uses_rt(i_br_type) ? w_need_src[1] : 2'd0;
  assign o_need      = (w_need_src[0] > w_need_b) ? w_need_src[0] : w_need_b;
  assign o_fwd_a_sel = w_fwd_src[0];
  assign o_fwd_b_sel = w_fwd_src[1];

endmodule

// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
// Purpose : sequences ID-stage branch resolution. Stalls the front end until
//           the branch operands can be forwarded, then enables the matching
//           comparator and, if taken, drives PC select and IF flush for a
//           single commit cycle.
// Config  : BRANCH_PERF_EN adds saturating perf counters (branches committed,
//           branches taken, cycles with br_stall) and their output ports.
// Ports   :
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_id_valid           ID holds a valid instruction
//   i_br_type            BR_* code
//   i_rs, i_rt           ID source registers
//   i_ex_*/i_mem_*/i_wb_* producer info per stage
//   i_ext_stall          global freeze; nothing advances or commits
//   i_cmp_out            comparator result
//   o_beq..o_bgtz        one-hot comparator enables (resolve cycles only)
//   o_fwd_a_sel/b_sel    comparator operand sources
//   o_br_stall           hold PC and IF/ID, bubble into EX
//   o_pc_src_br          take branch target this cycle
//   o_if_flush           squash IF/ID this cycle
//   o_perf_*             perf counters (BRANCH_PERF_EN only)
// -----------------------------------------------------------------------------
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 2
`ifdef BRANCH_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [2:0]        i_br_type,
  input  logic [RA_W-1:0]   i_rs,
  input  logic [RA_W-1:0]   i_rt,
  input  logic              i_ex_regwrite,
  input  logic              i_ex_memread,
  input  logic [RA_W-1:0]   i_ex_rd,
  input  logic              i_mem_regwrite,
  input  logic              i_mem_memread,
  input  logic [RA_W-1:0]   i_mem_rd,
  input  logic              i_wb_regwrite,
  input  logic [RA_W-1:0]   i_wb_rd,
  input  logic              i_ext_stall,
  input  logic              i_cmp_out,
  output logic              o_beq,
  output logic              o_bne,
  output logic              o_bgez,
  output logic              o_bgtz,
  output logic [1:0]        o_fwd_a_sel,
  output logic [1:0]        o_fwd_b_sel,
  output logic              o_br_stall,
  output logic              o_pc_src_br,
  output logic              o_if_flush
`ifdef BRANCH_PERF_EN
  , output logic [PERF_W-1:0] o_perf_branches
  , output logic [PERF_W-1:0] o_perf_taken
  , output logic [PERF_W-1:0] o_perf_stall_cycles
`endif
);

  logic [1:0]       w_need;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [2:0]       r_br_type, w_br_type_next;
  logic             w_is_br;
  logic             w_abort;
  logic             w_stall;
  logic             w_resolve;
  logic             w_run;
  logic             w_commit;

  branch_hazard_detect #(.RA_W(RA_W)) u_hazard (
    .i_br_type      (i_br_type),
    .i_rs           (i_rs),
    .i_rt           (i_rt),
    .i_ex_regwrite  (i_ex_regwrite),
    .i_ex_memread   (i_ex_memread),
    .i_ex_rd        (i_ex_rd),
    .i_mem_regwrite (i_mem_regwrite),
    .i_mem_memread  (i_mem_memread),
    .i_mem_rd       (i_mem_rd),
    .i_wb_regwrite  (i_wb_regwrite),
    .i_wb_rd        (i_wb_rd),
    .o_need         (w_need),
    .o_fwd_a_sel    (w_fwd_a),
    .o_fwd_b_sel    (w_fwd_b)
  );

  assign w_is_br = i_id_valid & (i_br_type != BR_NONE);
  // The stalled branch left ID (upstream flush or replacement): drop it.
  assign w_abort = ~i_id_valid | (i_br_type != r_br_type);

  // The IDLE cycle that detects the hazard is already the first stall cycle,
  // so the counter holds the stall cycles still to come after it. This makes
  // br_stall high for exactly `need` advancing cycles.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_br_type_next = r_br_type;
    w_stall        = 1'b0;
    w_resolve      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_br) begin
          if (w_need == 2'd0) begin
            w_resolve = 1'b1;
          end else begin
            w_stall = 1'b1;
            if (!i_ext_stall) begin
              w_cnt_next     = CNT_W'(w_need - 2'd1);
              w_br_type_next = i_br_type;
              w_state_next   = (w_need == 2'd1) ? ST_RESOLVE : ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        w_stall = 1'b1;
        if (w_abort) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (!i_ext_stall) begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_next = ST_RESOLVE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end
        end
      end
      ST_RESOLVE: begin
        if (w_abort) begin
          w_state_next = ST_IDLE;
        end else begin
          w_resolve = 1'b1;
          if (!i_ext_stall) w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_br_type <= BR_NONE;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_br_type <= w_br_type_next;
    end
  end

  // Outputs are forced low while reset is held so a stall in progress drops
  // without waiting for a clock edge.
  assign w_run    = ~i_reset;
  assign w_commit = w_run & w_resolve & ~i_ext_stall;

  assign o_beq       = w_run & w_resolve & (i_br_type == BR_BEQ);
  assign o_bne       = w_run & w_resolve & (i_br_type == BR_BNE);
  assign o_bgez      = w_run & w_resolve & (i_br_type == BR_BGEZ);
  assign o_bgtz      = w_run & w_resolve & (i_br_type == BR_BGTZ);
  assign o_fwd_a_sel = w_run ? w_fwd_a : 2'd0;
  assign o_fwd_b_sel = w_run ? w_fwd_b : 2'd0;
  assign o_br_stall  = w_run & w_stall;
  assign o_pc_src_br = w_commit & i_cmp_out;
  assign o_if_flush  = w_commit & i_cmp_out;

`ifdef BRANCH_PERF_EN
  logic [PERF_W-1:0] r_perf_branches;
  logic [PERF_W-1:0] r_perf_taken;
  logic [PERF_W-1:0] r_perf_stall_cycles;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_perf_branches     <= '0;
      r_perf_taken        <= '0;
      r_perf_stall_cycles <= '0;
    end else begin
      if (w_commit && (r_perf_branches != '1))
        r_perf_branches <= r_perf_branches + PERF_W'(1);
      if (w_commit && i_cmp_out && (r_perf_taken != '1))
        r_perf_taken <= r_perf_taken + PERF_W'(1);
      if (w_stall && (r_perf_stall_cycles != '1))
        r_perf_stall_cycles <= r_perf_stall_cycles + PERF_W'(1);
    end
  end

  assign o_perf_branches     = r_perf_branches;
  assign o_perf_taken        = r_perf_taken;
  assign o_perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
// Directed scenarios followed by randomized traffic, every cycle compared
// against a reference model that tracks a pending branch as "stall cycles
// still owed" rather than as FSM states.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [2:0] br_type;
  logic [4:0] rs, rt;
  logic       ex_regwrite, ex_memread;
  logic [4:0] ex_rd;
  logic       mem_regwrite, mem_memread;
  logic [4:0] mem_rd;
  logic       wb_regwrite;
  logic [4:0] wb_rd;
  logic       ext_stall, cmp_out;
  logic       beq, bne, bgez, bgtz, br_stall, pc_src_br, if_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef BRANCH_PERF_EN
  logic [31:0] perf_branches, perf_taken, perf_stall_cycles;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // reference model state
  int m_pending = 0;   // a stalled branch is being tracked
  int m_left    = 0;   // stall cycles still owed before resolving
  int m_type    = 0;
  int m_br = 0, m_tk = 0, m_st = 0;
  // values computed by eval, applied by adv
  int n_pending, n_left, n_type;
  bit e_stall, e_commit, e_taken;

  branch_resolve_ctrl dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_id_valid     (id_valid),
    .i_br_type      (br_type),
    .i_rs           (rs),
    .i_rt           (rt),
    .i_ex_regwrite  (ex_regwrite),
    .i_ex_memread   (ex_memread),
    .i_ex_rd        (ex_rd),
    .i_mem_regwrite (mem_regwrite),
    .i_mem_memread  (mem_memread),
    .i_mem_rd       (mem_rd),
    .i_wb_regwrite  (wb_regwrite),
    .i_wb_rd        (wb_rd),
    .i_ext_stall    (ext_stall),
    .i_cmp_out      (cmp_out),
    .o_beq          (beq),
    .o_bne          (bne),
    .o_bgez         (bgez),
    .o_bgtz         (bgtz),
    .o_fwd_a_sel    (fwd_a_sel),
    .o_fwd_b_sel    (fwd_b_sel),
    .o_br_stall     (br_stall),
    .o_pc_src_br    (pc_src_br),
    .o_if_flush     (if_flush)
`ifdef BRANCH_PERF_EN
    , .o_perf_branches     (perf_branches)
    , .o_perf_taken        (perf_taken)
    , .o_perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  function automatic int src_need(input int r);
    if (r == 0) return 0;
    if (ex_regwrite && int'(ex_rd) == r) return ex_memread ? 2 : 1;
    if (mem_regwrite && mem_memread && int'(mem_rd) == r) return 1;
    return 0;
  endfunction

  function automatic int fsel(input int r);
    if (r == 0) return 0;
    if (mem_regwrite && !mem_memread && int'(mem_rd) == r) return 1;
    if (wb_regwrite && int'(wb_rd) == r) return 2;
    return 0;
  endfunction

  // Mid-cycle: compute expected outputs from the model and compare.
  task automatic eval();
    int need, t;
    bit res;
    logic [10:0] got, exp;
    #3;
    t = int'(br_type);
    res = 0; e_stall = 0;
    n_pending = m_pending; n_left = m_left; n_type = m_type;
    exp = '0;
    if (!rst) begin
      need = src_need(int'(rs));
      if ((t == 1 || t == 2) && src_need(int'(rt)) > need) need = src_need(int'(rt));
      if (m_pending == 0) begin
        if (id_valid && t != 0) begin
          if (need == 0) res = 1;
          else begin
            e_stall = 1;
            if (!ext_stall) begin n_pending = 1; n_left = need - 1; n_type = t; end
          end
        end
      end else if (!id_valid || t != m_type) begin
        e_stall = (m_left > 0);
        n_pending = 0;
      end else if (m_left > 0) begin
        e_stall = 1;
        if (!ext_stall) n_left = m_left - 1;
      end else begin
        res = 1;
        if (!ext_stall) n_pending = 0;
      end
      e_commit = res && !ext_stall;
      e_taken  = e_commit && cmp_out;
      exp = {res && t == 1, res && t == 2, res && t == 3, res && t == 4,
             2'(fsel(int'(rs))), 2'(fsel(int'(rt))), e_stall, e_taken, e_taken};
    end else begin
      e_commit = 0; e_taken = 0;
    end
    got = {beq, bne, bgez, bgtz, fwd_a_sel, fwd_b_sel, br_stall, pc_src_br, if_flush};
    check("outs", {21'd0, got}, {21'd0, exp});
`ifdef BRANCH_PERF_EN
    check("perf_br", perf_branches,     rst ? 0 : m_br);
    check("perf_tk", perf_taken,        rst ? 0 : m_tk);
    check("perf_st", perf_stall_cycles, rst ? 0 : m_st);
`endif
    $display("cyc %0d rst=%0b v=%0b ty=%0d rs=%0d rt=%0d ext=%0b -> stall=%0b en=%b pc=%0b fa=%0d fb=%0d",
             cyc, rst, id_valid, br_type, rs, rt, ext_stall, br_stall,
             {beq, bne, bgez, bgtz}, pc_src_br, fwd_a_sel, fwd_b_sel);
  endtask

  // Clock edge: advance the model, then move to just after the edge.
  task automatic adv();
    @(posedge clk);
    if (rst) begin
      m_pending = 0; m_left = 0; m_type = 0; m_br = 0; m_tk = 0; m_st = 0;
    end else begin
      m_pending = n_pending; m_left = n_left; m_type = n_type;
      if (e_commit) m_br++;
      if (e_taken)  m_tk++;
      if (e_stall)  m_st++;
    end
    cyc++;
    #1;
  endtask

  task automatic clr_prod();
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    wb_regwrite = 0; wb_rd = 0;
  endtask

  task automatic set_id(input logic v, input logic [2:0] t, input logic [4:0] a, input logic [4:0] b);
    id_valid = v; br_type = t; rs = a; rt = b;
  endtask

  task automatic idle_cycle();
    set_id(0, 0, 0, 0); clr_prod(); ext_stall = 0;
    eval(); check("idle_pc", {31'd0, pc_src_br}, 0); adv();
  endtask

  int stall_cnt, pulse_cnt;
  bit last_stall;

  initial begin
    rst = 1; set_id(0, 0, 0, 0); clr_prod(); ext_stall = 0; cmp_out = 0;
    @(posedge clk); #1;
    // reset state, even with a hazard-causing branch presented
    set_id(1, 3'd1, 5'd4, 5'd4); ex_regwrite = 1; ex_rd = 4; ex_memread = 1;
    eval(); check("rst_stall", {31'd0, br_stall}, 0); adv();
    rst = 0; idle_cycle();

    // 1: BEQ no producers, resolves in the same cycle
    set_id(1, 3'd1, 5'd3, 5'd4); cmp_out = 1;
    eval();
    check("t1_beq", {31'd0, beq}, 1); check("t1_pc", {31'd0, pc_src_br}, 1);
    check("t1_flush", {31'd0, if_flush}, 1); check("t1_stall", {31'd0, br_stall}, 0);
    adv(); idle_cycle();

    // 2: BNE rs=5 behind EX ALU -> one stall, then EX/MEM forward
    set_id(1, 3'd2, 5'd5, 5'd9); ex_regwrite = 1; ex_rd = 5; cmp_out = 0;
    eval(); check("t2_stall", {31'd0, br_stall}, 1); adv();
    clr_prod(); mem_regwrite = 1; mem_rd = 5;
    eval();
    check("t2_fwd_a", {30'd0, fwd_a_sel}, 1); check("t2_bne", {31'd0, bne}, 1);
    check("t2_stall2", {31'd0, br_stall}, 0); check("t2_pc", {31'd0, pc_src_br}, 0);
    adv(); idle_cycle();

    // 3: BGEZ rs=7 behind EX load -> two stalls, then MEM/WB forward
    set_id(1, 3'd3, 5'd7, 5'd0); ex_regwrite = 1; ex_memread = 1; ex_rd = 7; cmp_out = 1;
    eval(); check("t3_st1", {31'd0, br_stall}, 1); adv();
    clr_prod(); mem_regwrite = 1; mem_memread = 1; mem_rd = 7;
    eval(); check("t3_st2", {31'd0, br_stall}, 1); adv();
    clr_prod(); wb_regwrite = 1; wb_rd = 7;
    eval();
    check("t3_fwd_a", {30'd0, fwd_a_sel}, 2); check("t3_bgez", {31'd0, bgez}, 1);
    check("t3_stall", {31'd0, br_stall}, 0);
    adv(); idle_cycle();

    // 4: r0 never creates a hazard
    set_id(1, 3'd1, 5'd0, 5'd0); ex_regwrite = 1; ex_memread = 1; ex_rd = 0;
    eval();
    check("t4_stall", {31'd0, br_stall}, 0); check("t4_fwd", {28'd0, fwd_a_sel, fwd_b_sel}, 0);
    adv(); idle_cycle();

    // 5: two-cycle stall with a three-cycle freeze inside it
    stall_cnt = 0; pulse_cnt = 0; cmp_out = 1;
    set_id(1, 3'd1, 5'd6, 5'd8); ex_regwrite = 1; ex_memread = 1; ex_rd = 8;
    eval(); stall_cnt += br_stall; pulse_cnt += pc_src_br; adv();
    clr_prod(); mem_regwrite = 1; mem_memread = 1; mem_rd = 8; ext_stall = 1;
    for (int i = 0; i < 3; i++) begin
      eval(); stall_cnt += br_stall; pulse_cnt += pc_src_br; adv();
    end
    ext_stall = 0;
    eval(); stall_cnt += br_stall; pulse_cnt += pc_src_br; adv();
    clr_prod(); wb_regwrite = 1; wb_rd = 8;
    eval(); stall_cnt += br_stall; pulse_cnt += pc_src_br;
    check("t5_beq", {31'd0, beq}, 1); adv();
    idle_cycle();
    check("t5_stalls", stall_cnt, 5); check("t5_pulses", pulse_cnt, 1);

    // 6: reset while waiting, then a clean BGTZ
    set_id(1, 3'd4, 5'd2, 5'd0); ex_regwrite = 1; ex_memread = 1; ex_rd = 2;
    eval(); adv();
    eval(); check("t6_wait", {31'd0, br_stall}, 1);
    rst = 1; #1; check("t6_rst_now", {31'd0, br_stall}, 0); adv();
    rst = 0; clr_prod(); cmp_out = 1;
    eval(); check("t6_bgtz", {31'd0, bgtz}, 1); check("t6_pc", {31'd0, pc_src_br}, 1);
`ifdef BRANCH_PERF_EN
    check("t6_perf0", perf_branches, 0);
`endif
    adv();
    idle_cycle();
`ifdef BRANCH_PERF_EN
    check("t6_perf1", perf_branches, 1);
`endif

    // randomized traffic: hold a stalled branch in ID most of the time
    last_stall = 0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!(last_stall && $urandom_range(0, 19) != 0)) begin
        id_valid = ($urandom_range(0, 4) != 0);
        br_type  = 3'($urandom_range(0, 4));
        rs       = 5'($urandom_range(0, 3));
        rt       = 5'($urandom_range(0, 3));
      end
      ex_regwrite = 1'($urandom); ex_memread = 1'($urandom); ex_rd = 5'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom); mem_memread = 1'($urandom); mem_rd = 5'($urandom_range(0, 3));
      wb_regwrite = 1'($urandom); wb_rd = 5'($urandom_range(0, 3));
      ext_stall = ($urandom_range(0, 5) == 0);
      cmp_out = 1'($urandom);
      eval();
      last_stall = e_stall;
      adv();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
